// File: rtl/secure_reg_bank.sv
// secure_reg_bank
// Bank of sensitive data registers guarded by a two-word key unlock.
// Only a privileged requester may unlock, write or set sticky locks, and only
// while the bank is UNLOCKED. The unlock window closes on relock, on any key
// word, or after TIMEOUT idle cycles. Unprivileged reads return zero.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   priv                    requester is privileged (qualifies this cycle)
//   key_valid, key_data     key word presented
//   relock                  force return to LOCKED
//   wr_en/wr_addr/wr_data   data write request
//   lock_en/lock_addr       sticky lock request
//   rd_en/rd_addr           read request
//   rd_data, rd_valid       registered read response (one cycle after rd_en)
//   wr_ack, wr_err          registered accept / reject pulses
//   unlocked                registered "state is UNLOCKED"
//   sticky_q                per-register sticky lock bits
//   viol_cnt                saturating violation count
//
// state    | meaning
// ---------+-------------------------------------------------
// LOCKED   | no writes; waiting for the first key word
// ARMED    | first key word seen; waiting for its complement
// UNLOCKED | privileged writes and locks accepted

module secure_reg_bank #(
    parameter int                DATA_W     = 32,
    parameter int                NUM_REGS   = 4,
    parameter int                ADDR_W     = 2,
    parameter logic [DATA_W-1:0] UNLOCK_KEY = 32'hC0DE_5EC7,
    parameter int                TIMEOUT    = 16,
    parameter int                VIOL_W     = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                priv,
    input  logic                key_valid,
    input  logic [DATA_W-1:0]   key_data,
    input  logic                relock,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                lock_en,
    input  logic [ADDR_W-1:0]   lock_addr,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    output logic                wr_ack,
    output logic                wr_err,
    output logic                unlocked,
    output logic [NUM_REGS-1:0] sticky_q,
    output logic [VIOL_W-1:0]   viol_cnt
);

    localparam int NSLOT = 2 ** ADDR_W;
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {LOCKED, ARMED, UNLOCKED} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  idle_cnt, idle_nxt;
    logic [DATA_W-1:0] regs [NUM_REGS];

    // Address map padded to the full address space so out-of-range
    // addresses index safely and read as "invalid, not locked".
    logic [NSLOT-1:0]  slot_valid, sticky_ext;
    logic              req_ok, wr_acc, wr_rej, lock_acc, lock_rej;
    logic              key_first, key_second, key_viol, idle_hit, viol_any;

    always_comb begin
        slot_valid                = '0;
        slot_valid[NUM_REGS-1:0]  = '1;
        sticky_ext                = '0;
        sticky_ext[NUM_REGS-1:0]  = sticky_q;
    end

    // A key word or relock in the same cycle closes the window, so it
    // overrides any write or lock request.
    assign req_ok   = priv && (state == UNLOCKED) && !relock && !key_valid;
    assign wr_acc   = wr_en && req_ok && slot_valid[wr_addr] && !sticky_ext[wr_addr];
    assign wr_rej   = wr_en && !wr_acc;
    assign lock_acc = lock_en && req_ok && slot_valid[lock_addr];
    assign lock_rej = lock_en && !lock_acc;

    assign key_first  = key_valid && priv && (key_data == UNLOCK_KEY);
    assign key_second = key_valid && priv && (key_data == ~UNLOCK_KEY);
    // In UNLOCKED no key word is expected, so every key word there counts.
    assign key_viol   = key_valid && !(((state == LOCKED) && key_first) ||
                                       ((state == ARMED)  && key_second));
    assign viol_any   = wr_rej || lock_rej || key_viol;
    assign idle_hit   = (idle_cnt == IDLE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= LOCKED;
            idle_cnt <= '0;
        end else begin
            state    <= state_nxt;
            idle_cnt <= idle_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idle_nxt  = idle_cnt;
        case (state)
            LOCKED: begin
                if (key_first) state_nxt = ARMED;
            end
            ARMED: begin
                if (key_second)
                    state_nxt = UNLOCKED;
                else if (key_valid || wr_en || relock || idle_hit)
                    state_nxt = LOCKED;
            end
            UNLOCKED: begin
                if (relock || key_valid)
                    state_nxt = LOCKED;
                else if (idle_hit && !wr_acc)
                    state_nxt = LOCKED;
            end
            default: state_nxt = LOCKED;
        endcase
        // The counter only matters in ARMED/UNLOCKED; hold it at zero in
        // LOCKED so it can never wrap.
        if ((state_nxt != state) || wr_acc || (state_nxt == LOCKED))
            idle_nxt = '0;
        else
            idle_nxt = idle_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            sticky_q <= '0;
        end else begin
            if (wr_acc)   regs[wr_addr]       <= wr_data;
            if (lock_acc) sticky_q[lock_addr] <= 1'b1;
        end
    end

    // A same-cycle write is not yet visible, so the read returns old data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            wr_ack   <= 1'b0;
            wr_err   <= 1'b0;
            unlocked <= 1'b0;
            viol_cnt <= '0;
        end else begin
            rd_valid <= rd_en;
            rd_data  <= (rd_en && priv && slot_valid[rd_addr]) ? regs[rd_addr] : '0;
            wr_err   <= wr_rej || lock_rej;
            wr_ack   <= wr_acc && !lock_rej;
            unlocked <= (state_nxt == UNLOCKED);
            if (viol_any && (viol_cnt != '1))
                viol_cnt <= viol_cnt + VIOL_W'(1);
        end
    end

endmodule

// File: doc/secure_reg_bank.md
# secure_reg_bank

Parametrised bank of sensitive registers with access control. Data registers are writable only by a privileged master after a two-step key unlock. The unlock window closes on an idle timeout or an explicit relock. Per-register sticky locks, read masking for unprivileged masters and a saturating violation counter are included. The block sits between the system register bus and security-critical configuration state such as keys, fuse shadows and debug enables.

## Interface
- DATA_W, 32: register and key width
- NUM_REGS, 4: number of data registers
- ADDR_W, 2: address width; must satisfy 2^ADDR_W >= NUM_REGS
- UNLOCK_KEY, 32'hC0DE_5EC7: first key word, DATA_W bits; the second word is ~UNLOCK_KEY
- TIMEOUT, 16: idle cycles before auto-relock, >= 2
- VIOL_W, 8: violation counter width
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- priv  in  1  requester is privileged; qualifies every request in the same cycle
- key_valid  in  1  key word presented
- key_data  in  DATA_W  key word
- relock  in  1  force return to LOCKED
- wr_en  in  1  data write request
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- lock_en  in  1  set sticky lock
- lock_addr  in  ADDR_W  sticky lock target
- rd_en  in  1  read request
- rd_addr  in  ADDR_W  read address
- rd_data  out  DATA_W  read data
- rd_valid  out  1  rd_data valid pulse
- wr_ack  out  1  write accepted pulse
- wr_err  out  1  write or lock rejected pulse
- unlocked  out  1  state == UNLOCKED
- sticky_q  out  NUM_REGS  sticky lock bits
- viol_cnt  out  VIOL_W  saturating violation count

## Operation
- States are LOCKED, ARMED and UNLOCKED; reset enters LOCKED.
- LOCKED -> ARMED when key_valid && priv && key_data == UNLOCK_KEY.
- ARMED -> UNLOCKED when key_valid && priv && key_data == ~UNLOCK_KEY.
- ARMED -> LOCKED on any of: any other key_valid, wr_en, relock, or TIMEOUT cycles without key_valid.
- UNLOCKED -> LOCKED on any of: relock, any key_valid, or TIMEOUT consecutive cycles without an accepted write.
- Idle counter behaviour:
  - Clears on every state entry and on every accepted write.
  - Increments otherwise.
  - Transition fires on the edge where the counter equals TIMEOUT-1.
- A write is accepted iff all hold:
  - wr_en && priv
  - state == UNLOCKED
  - relock == 0 and key_valid == 0 in the same cycle
  - wr_addr < NUM_REGS
  - sticky_q[wr_addr] == 0
- An accepted write updates the register on the edge. Any other wr_en is rejected and the register is unchanged.
- Sticky lock follows the same acceptance rules, using lock_addr; the sticky_q bit already being set is not a rejection. An accepted lock sets sticky_q[lock_addr], which clears only on reset.
- If wr_en and lock_en target the same address in one cycle, the write is accepted first (it sees the old sticky bit), then the lock is set.
- Read behaviour:
  - rd_en produces rd_valid on the next cycle.
  - rd_data = register if priv was high at request and rd_addr < NUM_REGS; otherwise 0.
  - rd_data is 0 whenever rd_valid is 0.
  - A read in the same cycle as a write to the same address returns the old value.
- Violations are: a rejected write, a rejected lock, a key_valid with a wrong word in any state, and a key_valid with priv low.
- viol_cnt increments by at most 1 per cycle regardless of how many violations occur, and saturates at all-ones.

## Timing
- Reset values: all registers 0, sticky_q 0, viol_cnt 0, rd_data 0, rd_valid 0, wr_ack 0, wr_err 0, unlocked 0, state LOCKED, idle counter 0.
- Reset asserted mid-window immediately relocks and clears everything, including sticky bits.
- wr_ack and wr_err are registered one-cycle pulses, asserted the cycle after the request, and mutually exclusive.
- Write data is visible to a read issued the cycle after the write.
- unlocked is registered: it rises the cycle after the second key word and falls the cycle after the relocking event.
- Unlock needs at least 2 cycles; back-to-back key words are allowed.

## Test plan
- Unlock and write:
  - Stimulus: priv=1; key C0DE_5EC7 then 3F21_A138; write reg2=DEAD_BEEF; priv read reg2.
  - Required: unlocked=1; wr_ack; rd_data=DEAD_BEEF.
- Access denial:
  - Stimulus: while locked, write reg0=1234; then unlock and write with priv=0; then unprivileged read.
  - Required: both writes give wr_err, reg0 stays 0; viol_cnt=2; unprivileged read returns 0 with rd_valid=1.
- Bad key:
  - Stimulus: key C0DE_5EC7 then 0000_0000.
  - Required: state returns to LOCKED; viol_cnt increments; a following write is rejected.
- Timeout and relock priority:
  - Stimulus: unlock, then idle 16 cycles; separately, unlock then relock and wr_en in the same cycle.
  - Required: unlocked falls after exactly 16 idle cycles; the same-cycle write is rejected with wr_err.
- Sticky lock:
  - Stimulus: unlock; lock_en on reg1; write reg1=5.
  - Required: sticky_q=0010; wr_err; reg1 unchanged; sticky survives relock/unlock and clears only on rst_n.
- Saturation and reset:
  - Stimulus: VIOL_W=8; 300 rejected writes; then assert rst_n low mid-unlock.
  - Required: viol_cnt=FF; after reset all outputs return to their reset values.
